// File: rtl/multi_cycle_shifter_if.sv
// Request/response bundle for multi_cycle_shifter.
// master drives requests, slave returns the result.
interface multi_cycle_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output start, dataA, dataB, Signal,
    input  busy, done, err, dataOut
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output busy, done, err, dataOut
  );
endinterface

// File: rtl/multi_cycle_shifter.sv
// Iterative SLL/SRL/SRA shifter, up to STEP bits per clock.
// Define SHIFTER_ROTATE_EN to add ROL/ROR.
module multi_cycle_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_cycle_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
`ifdef SHIFTER_ROTATE_EN
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
`endif

  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_ROL = 6'b000100;
  localparam logic [5:0] OP_ROR = 6'b000110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] out_q;
  logic [SHW:0]     rem_q;
  logic [SHW:0]     k;
  logic [5:0]       op_q;
  logic             ok_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             legal;
  logic             unused_b;

  assign unused_b    = ^bus.dataB[WIDTH-1:SHW];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.dataOut = out_q;

  always_comb begin
    legal = 1'b0;
    case (bus.Signal)
      OP_SLL, OP_SRL, OP_SRA: legal = 1'b1;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         legal = 1'b1;
`endif
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    k   = (rem_q > STEP_W) ? STEP_W : rem_q;
    w_d = w_q;
    case (op_q)
      OP_SLL: w_d = w_q << k;
      OP_SRL: w_d = w_q >> k;
      OP_SRA: w_d = $signed(w_q) >>> k;
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: w_d = (w_q << k) | (w_q >> (WIDTH_W - k));
      OP_ROR: w_d = (w_q >> k) | (w_q << (WIDTH_W - k));
`endif
      default: w_d = w_q;
    endcase
  end

  // Zero-amount and illegal requests still pass one SHIFT edge,
  // so every request reports done no earlier than one cycle in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            w_q     <= bus.dataA;
            op_q    <= bus.Signal;
            rem_q   <= {1'b0, bus.dataB[SHW-1:0]};
            ok_q    <= legal;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          w_q   <= w_d;
          rem_q <= rem_q - k;
          if (rem_q <= STEP_W) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            out_q   <= ok_q ? w_d : '0;
            err_q   <= ~ok_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Scoreboard bench for multi_cycle_shifter (WIDTH=32, STEP=4).
// Expected results follow SHIFTER_ROTATE_EN when defined.
module tb_multi_cycle_shifter;
  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    logic [31:0] val;
    logic        err;
    int          at;
    string       name;
  } exp_t;

  exp_t q[$];

  multi_cycle_shifter_if #(.WIDTH(32)) bus ();

  multi_cycle_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor
  logic        held_chk;
  logic [31:0] held_val;
  logic        held_err;
  exp_t        e;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_data"}, bus.dataOut, e.val);
          chk({e.name, "_err"}, 32'(bus.err), 32'(e.err));
          chk({e.name, "_cycle"}, cyc, e.at);
        end
        held_chk = 1'b1;
        held_val = bus.dataOut;
        held_err = bus.err;
      end else if (held_chk) begin
        held_chk = 1'b0;
        chk("post_done_busy", 32'(bus.busy), 32'd0);
        chk("hold_data", bus.dataOut, held_val);
        chk("hold_err", 32'(bus.err), 32'(held_err));
      end
    end else begin
      held_chk = 1'b0;
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] val,
                       input logic er, input int lat, input string nm,
                       input bit push, output int cap);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    bus.start  = 1'b1;
    bus.Signal = op;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    #1;
    cap        = cyc;
    bus.start  = 1'b0;
    bus.dataA  = 32'h5A5A_A5A5;
    bus.dataB  = 32'h0000_001F;
    bus.Signal = 6'b000011;
    if (push) q.push_back('{val, er, cap + lat, nm});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  logic [31:0] ror_v;
  logic [31:0] rol_v;
  logic        rot_e;
  int          cap;

  initial begin
`ifdef SHIFTER_ROTATE_EN
    ror_v = 32'h8000_0000;
    rol_v = 32'h0000_0018;
    rot_e = 1'b0;
`else
    ror_v = 32'h0;
    rol_v = 32'h0;
    rot_e = 1'b1;
`endif
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    held_chk   = 1'b0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.Signal = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_data", bus.dataOut, 32'd0);

    issue(6'b000010, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 8, "srl31", 1, cap);
    issue(6'b000011, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, "sra4", 1, cap);
    issue(6'b000000, 32'h0000_0001, 32'd0, 32'h0000_0001, 1'b0, 1, "sll0", 1, cap);
    issue(6'b000000, 32'h0000_0003, 32'd33, 32'h0000_0006, 1'b0, 1, "sll33", 1, cap);
    issue(6'b000110, 32'h0000_0001, 32'd1, ror_v, rot_e, 1, "ror1", 1, cap);
    issue(6'b111111, 32'h1234_5678, 32'd3, 32'h0, 1'b1, 1, "bad3f", 1, cap);
    issue(6'b000011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 8, "sra31", 1, cap);
    issue(6'b000001, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b1, 1, "bad01", 1, cap);
    issue(6'b000011, 32'h4000_0000, 32'd8, 32'h0040_0000, 1'b0, 2, "sra8", 1, cap);
    issue(6'b000000, 32'h1234_5678, 32'd5, 32'h468A_CF00, 1'b0, 2, "sll5", 1, cap);
    issue(6'b000010, 32'hF000_0000, 32'd6, 32'h03C0_0000, 1'b0, 2, "srl6", 1, cap);
    issue(6'b000100, 32'h8000_0001, 32'd4, rol_v, rot_e, 1, "rol4", 1, cap);
    issue(6'b000010, 32'hFFFF_FFFF, 32'd7, 32'h01FF_FFFF, 1'b0, 2, "srl7", 1, cap);
    drain("vectors");

    // a start while busy must be dropped
    issue(6'b000010, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 8, "busy_srl", 1, cap);
    while (cyc < cap + 3) @(negedge clk);
    bus.start  = 1'b1;
    bus.Signal = 6'b000000;
    bus.dataA  = 32'h0000_00FF;
    bus.dataB  = 32'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain("ignore");

    // reset mid-flight discards the result
    issue(6'b000010, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 8, "abort", 0, cap);
    while (cyc < cap + 5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_data", bus.dataOut, 32'd0);
    repeat (15) @(negedge clk);
    issue(6'b000000, 32'h0000_0001, 32'd1, 32'h0000_0002, 1'b0, 1, "after_rst", 1, cap);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
